// File: rtl/regfile_scanner.sv
// ---------------------------------------------------------------------------
// regfile_scanner
//
// Read-side master for the 32x32 register file read ports. A start pulse
// walks every register in pairs: port A reads the even index and port B the
// odd index of the same pair. The pair is captured in one cycle, and the two
// words are streamed out as (index, data) on a valid/ready port. This is the
// debug and dump path, used for state dumps and the board-state readout.
//
// Build option:
//   REGSCAN_CHECKSUM_EN - when defined, checksum is a running XOR of every
//                         word accepted since the last start. When undefined,
//                         checksum is tied to 0 and no XOR logic is built.
//                         The port list is the same in both builds.
//
// Ports:
//   clock          in   1       system clock, rising edge
//   ctrl_reset_n   in   1       asynchronous active-low reset
//   start          in   1       1-cycle pulse, begins a scan (ignored while busy)
//   abort          in   1       synchronous, stops the scan and returns to idle
//   busy           out  1       high while a scan is in progress
//   done           out  1       1-cycle pulse after the last word is accepted
//   ctrl_readRegA  out  ADDR_W  regfile port A address (even index)
//   ctrl_readRegB  out  ADDR_W  regfile port B address (odd index)
//   data_readRegA  in   DATA_W  regfile port A data, combinational from address
//   data_readRegB  in   DATA_W  regfile port B data, combinational from address
//   out_valid      out  1       stream word valid
//   out_ready      in   1       stream word accepted when valid && ready at posedge
//   out_index      out  ADDR_W  register number of out_data
//   out_data       out  DATA_W  register contents
//   checksum       out  DATA_W  XOR of all emitted words (0 without the option)
//
// Stream handshake: a word transfers on a rising edge where out_valid and
// out_ready are both high. Once out_valid rises, out_index and out_data hold
// until that transfer. out_valid only drops without a transfer on abort or
// reset. out_ready may stall for any number of cycles.
// ---------------------------------------------------------------------------
module regfile_scanner #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clock,
    input  logic              ctrl_reset_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ctrl_readRegA,
    output logic [ADDR_W-1:0] ctrl_readRegB,
    input  logic [DATA_W-1:0] data_readRegA,
    input  logic [DATA_W-1:0] data_readRegB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_SEND_A = 3'd2,
        S_SEND_B = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_TWO  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    // The read addresses double as the scan pointer: rd_a_q is the even
    // index of the current pair, rd_b_q the odd one.
    logic [ADDR_W-1:0] rd_a_q, rd_a_d;
    logic [ADDR_W-1:0] rd_b_q, rd_b_d;
    logic [DATA_W-1:0] buf_a_q, buf_a_d;
    logic [DATA_W-1:0] buf_b_q, buf_b_d;

    logic start_ok;
    logic word_accept;

    // abort beats start even in idle, so a simultaneous pair starts nothing.
    assign start_ok    = (state_q == S_IDLE) && start && !abort;
    // A transfer coinciding with abort is dropped: the scan is gone.
    assign word_accept = out_valid && out_ready && !abort;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        rd_a_d  = rd_a_q;
        rd_b_d  = rd_b_q;
        buf_a_d = buf_a_q;
        buf_b_d = buf_b_q;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    rd_a_d  = '0;
                    rd_b_d  = IDX_ONE;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // Addresses have been stable since the previous edge, so the
                // combinational read data is valid to capture now.
                buf_a_d = data_readRegA;
                buf_b_d = data_readRegB;
                state_d = S_SEND_A;
            end
            S_SEND_A: begin
                if (out_ready) begin
                    state_d = S_SEND_B;
                end
            end
            S_SEND_B: begin
                if (out_ready) begin
                    if (rd_b_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        rd_a_d  = rd_a_q + IDX_TWO;
                        rd_b_d  = rd_b_q + IDX_TWO;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                rd_a_d  = '0;
                rd_b_d  = IDX_ONE;
                state_d = S_IDLE;
            end
            default: begin
                rd_a_d  = '0;
                rd_b_d  = IDX_ONE;
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            rd_a_d  = '0;
            rd_b_d  = IDX_ONE;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q <= S_IDLE;
            rd_a_q  <= '0;
            rd_b_q  <= IDX_ONE;
            buf_a_q <= '0;
            buf_b_q <= '0;
        end else begin
            state_q <= state_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
            buf_a_q <= buf_a_d;
            buf_b_q <= buf_b_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from the state and the captured pair)
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = 1'b0;
        out_index = '0;
        out_data  = '0;
        case (state_q)
            S_SEND_A: begin
                out_valid = 1'b1;
                out_index = rd_a_q;
                out_data  = buf_a_q;
            end
            S_SEND_B: begin
                out_valid = 1'b1;
                out_index = rd_b_q;
                out_data  = buf_b_q;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    // busy is already low in the DONE cycle, so it falls together with done.
    assign busy = (state_q == S_FETCH) || (state_q == S_SEND_A) || (state_q == S_SEND_B);
    assign done = (state_q == S_DONE);

    assign ctrl_readRegA = rd_a_q;
    assign ctrl_readRegB = rd_b_q;

    // ------------------------------------------------------------------
    // Optional running checksum
    // ------------------------------------------------------------------
`ifdef REGSCAN_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (start_ok) begin
            csum_d = '0;
        end else if (word_accept) begin
            csum_d = csum_q ^ out_data;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    logic unused_accept;
    assign unused_accept = word_accept;
    assign checksum      = '0;
`endif

endmodule
